// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester handshakes and memory-side bus of the data-memory arbiter
interface dmem_arbiter_if #(parameter int ERR_CNT_W = 16);
  logic                 w_req_0, w_req_1;
  logic [31:0]          w_addr_0, w_addr_1;
  logic [31:0]          w_wdata_0, w_wdata_1;
  logic                 w_write_0, w_write_1;
  logic                 w_byte_0, w_byte_1;
  logic                 w_gnt_0, w_gnt_1;
  logic                 w_done_0, w_done_1;
  logic                 w_err_0, w_err_1;
  logic [31:0]          w_rdata;
  logic [31:0]          w_mem_addr;
  logic [31:0]          w_mem_wdata;
  logic                 w_mem_write;
  logic                 w_mem_en;
  logic                 w_mem_byte;
  logic [31:0]          w_mem_rdata_32;
  logic [7:0]           w_mem_rdata_8;
  logic [ERR_CNT_W-1:0] w_err_count;
  modport master (
    output w_req_0, w_req_1, w_addr_0, w_addr_1, w_wdata_0, w_wdata_1,
    output w_write_0, w_write_1, w_byte_0, w_byte_1, w_mem_rdata_32, w_mem_rdata_8,
    input  w_gnt_0, w_gnt_1, w_done_0, w_done_1, w_err_0, w_err_1, w_rdata,
    input  w_mem_addr, w_mem_wdata, w_mem_write, w_mem_en, w_mem_byte, w_err_count
  );
  modport slave (
    input  w_req_0, w_req_1, w_addr_0, w_addr_1, w_wdata_0, w_wdata_1,
    input  w_write_0, w_write_1, w_byte_0, w_byte_1, w_mem_rdata_32, w_mem_rdata_8,
    output w_gnt_0, w_gnt_1, w_done_0, w_done_1, w_err_0, w_err_1, w_rdata,
    output w_mem_addr, w_mem_wdata, w_mem_write, w_mem_en, w_mem_byte, w_err_count
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter and range-checked access sequencer for the data memory
module dmem_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h80020000,
  parameter logic [31:0] MEM_DEPTH = 32'd1000000,
  parameter int          ERR_CNT_W = 16
) (
  input logic          clock,
  input logic          reset_n,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t               state, state_nx;
  logic                 ptr, port, port_nx, take, write, byte_op, err, legal;
  logic [31:0]          addr, wdata, rdata, off;
  logic [ERR_CNT_W-1:0] err_cnt;
  always_comb begin
    take     = (state == IDLE) ? (bus.w_req_0 | bus.w_req_1) :
               (state == RESP) ? (port ? bus.w_req_0 : bus.w_req_1) : 1'b0;
    port_nx  = (state == RESP) ? ~port : ((bus.w_req_0 && bus.w_req_1) ? ptr : bus.w_req_1);
    state_nx = take ? ACCESS : (state == ACCESS) ? RESP : IDLE;
  end
  assign off   = addr - BASE_ADDR;
  assign legal = byte_op ? (off <= MEM_DEPTH) : (off[1:0] == 2'b00 && off <= MEM_DEPTH - 32'd3);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      port    <= 1'b0;
      addr    <= '0;
      wdata   <= '0;
      write   <= 1'b0;
      byte_op <= 1'b0;
      rdata   <= '0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      state <= state_nx;
      if (take) begin
        port    <= port_nx;
        ptr     <= ~port_nx;
        addr    <= port_nx ? bus.w_addr_1  : bus.w_addr_0;
        wdata   <= port_nx ? bus.w_wdata_1 : bus.w_wdata_0;
        write   <= port_nx ? bus.w_write_1 : bus.w_write_0;
        byte_op <= port_nx ? bus.w_byte_1  : bus.w_byte_0;
      end
      if (state == ACCESS) begin
        rdata <= (!legal || write) ? 32'h0 : byte_op ? {24'h0, bus.w_mem_rdata_8} : bus.w_mem_rdata_32;
        err   <= ~legal;
        if (!legal && !(&err_cnt))
          err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
    end
  end
  assign bus.w_gnt_0     = (state == ACCESS) && !port;
  assign bus.w_gnt_1     = (state == ACCESS) && port;
  assign bus.w_done_0    = (state == RESP) && !port;
  assign bus.w_done_1    = (state == RESP) && port;
  assign bus.w_err_0     = bus.w_done_0 && err;
  assign bus.w_err_1     = bus.w_done_1 && err;
  assign bus.w_rdata     = rdata;
  assign bus.w_mem_addr  = addr;
  assign bus.w_mem_wdata = wdata;
  assign bus.w_mem_write = (state == ACCESS) && write;
  assign bus.w_mem_en    = (state == ACCESS) && legal;
  assign bus.w_mem_byte  = byte_op;
  assign bus.w_err_count = err_cnt;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench with a big-endian byte memory model
module tb_dmem_arbiter;
  localparam logic [31:0] BASE  = 32'h80020000;
  localparam int          DEPTH = 1000000;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  always #5 clock = ~clock;
  dmem_arbiter_if #(.ERR_CNT_W(16)) bus();
  dmem_arbiter #(.BASE_ADDR(BASE), .MEM_DEPTH(DEPTH), .ERR_CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );
  logic [7:0]  mem [0:DEPTH];
  logic [31:0] moff;
  always_comb begin
    moff = bus.w_mem_addr - BASE;
    bus.w_mem_rdata_32 = 32'h0;
    bus.w_mem_rdata_8  = 8'h0;
    if (moff <= DEPTH - 3)
      bus.w_mem_rdata_32 = {mem[moff], mem[moff + 1], mem[moff + 2], mem[moff + 3]};
    if (moff <= DEPTH)
      bus.w_mem_rdata_8 = mem[moff];
  end
  always @(posedge clock) begin
    if (bus.w_mem_en && bus.w_mem_write) begin
      if (bus.w_mem_byte)
        mem[moff] <= bus.w_mem_wdata[7:0];
      else begin
        mem[moff]     <= bus.w_mem_wdata[31:24];
        mem[moff + 1] <= bus.w_mem_wdata[23:16];
        mem[moff + 2] <= bus.w_mem_wdata[15:8];
        mem[moff + 3] <= bus.w_mem_wdata[7:0];
      end
    end
  end
  function automatic logic [31:0] word_at(input int o);
    return {mem[o], mem[o + 1], mem[o + 2], mem[o + 3]};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic op(input string tag, input bit p, input logic [31:0] a, input logic [31:0] d,
                    input bit wr, input bit bt, input logic [31:0] exp_rd, input bit exp_err);
    int          gl, dl;
    bit          en_seen, er;
    logic [31:0] rd;
    @(negedge clock);
    if (p) begin
      bus.w_addr_1 = a; bus.w_wdata_1 = d; bus.w_write_1 = wr; bus.w_byte_1 = bt; bus.w_req_1 = 1'b1;
    end else begin
      bus.w_addr_0 = a; bus.w_wdata_0 = d; bus.w_write_0 = wr; bus.w_byte_0 = bt; bus.w_req_0 = 1'b1;
    end
    gl = -1; dl = -1; en_seen = 1'b0; er = 1'b0; rd = 32'hx;
    for (int n = 1; n <= 8 && dl < 0; n++) begin
      @(posedge clock); #1;
      if ((p ? bus.w_gnt_1 : bus.w_gnt_0) && gl < 0) gl = n;
      en_seen |= bus.w_mem_en;
      if (p ? bus.w_done_1 : bus.w_done_0) begin
        dl = n;
        rd = bus.w_rdata;
        er = p ? bus.w_err_1 : bus.w_err_0;
      end
    end
    bus.w_req_0 = 1'b0;
    bus.w_req_1 = 1'b0;
    chk({tag, "/gnt_lat"}, 32'(gl), 32'd1);
    chk({tag, "/done_lat"}, 32'(dl), 32'd2);
    chk({tag, "/rdata"}, rd, exp_rd);
    chk({tag, "/err"}, 32'(er), 32'(exp_err));
    chk({tag, "/mem_en"}, 32'(en_seen), 32'(!exp_err));
    @(posedge clock);
  endtask
  task automatic chk_quiet(input string tag);
    chk({tag, "/flags"}, 32'({bus.w_gnt_0, bus.w_gnt_1, bus.w_done_0, bus.w_done_1, bus.w_err_0,
                             bus.w_err_1, bus.w_mem_en, bus.w_mem_write, bus.w_mem_byte}), 32'h0);
    chk({tag, "/rdata"}, bus.w_rdata, 32'h0);
    chk({tag, "/err_count"}, 32'(bus.w_err_count), 32'h0);
    chk({tag, "/mem_addr"}, bus.w_mem_addr, 32'h0);
    chk({tag, "/mem_wdata"}, bus.w_mem_wdata, 32'h0);
  endtask
  logic [3:0] rr_exp [8];
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    rr_exp = '{4'b1000, 4'b0010, 4'b0100, 4'b0001, 4'b1000, 4'b0010, 4'b0100, 4'b0001};
    bus.w_req_0 = 1'b0; bus.w_addr_0 = '0; bus.w_wdata_0 = '0; bus.w_write_0 = 1'b0; bus.w_byte_0 = 1'b0;
    bus.w_req_1 = 1'b0; bus.w_addr_1 = '0; bus.w_wdata_1 = '0; bus.w_write_1 = 1'b0; bus.w_byte_1 = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    #1 chk_quiet("reset");
    op("st_w", 1'b0, 32'h80020010, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("st_w/bytes", word_at(16), 32'hDEADBEEF);
    op("ld_w", 1'b0, 32'h80020010, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0);
    op("st_b", 1'b1, 32'h80020011, 32'h1234565A, 1'b1, 1'b1, 32'h0, 1'b0);
    chk("st_b/bytes", word_at(16), 32'hDE5ABEEF);
    op("ld_b", 1'b1, 32'h80020011, 32'h0, 1'b0, 1'b1, 32'h0000005A, 1'b0);
    op("ld_w2", 1'b0, 32'h80020010, 32'h0, 1'b0, 1'b0, 32'hDE5ABEEF, 1'b0);
    op("st_top", 1'b1, BASE + DEPTH, 32'h000000A5, 1'b1, 1'b1, 32'h0, 1'b0);
    op("ld_top", 1'b0, BASE + DEPTH, 32'h0, 1'b0, 1'b1, 32'h000000A5, 1'b0);
    op("mis", 1'b0, 32'h80020002, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    op("low", 1'b1, 32'h8001FFFF, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1);
    op("high", 1'b0, BASE + DEPTH - 2, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("err_count3", 32'(bus.w_err_count), 32'd3);
    @(negedge clock);
    bus.w_addr_0 = 32'h80020020; bus.w_wdata_0 = 32'h11223344; bus.w_write_0 = 1'b1;
    bus.w_byte_0 = 1'b0; bus.w_req_0 = 1'b1;
    @(posedge clock); #1;
    chk("rm/en_before", 32'(bus.w_mem_en), 32'd1);
    chk("rm/gnt_before", 32'(bus.w_gnt_0), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rm/en_drop", 32'(bus.w_mem_en), 32'd0);
    chk("rm/gnt_drop", 32'(bus.w_gnt_0), 32'd0);
    bus.w_req_0 = 1'b0;
    @(posedge clock); #1;
    chk("rm/no_write", word_at(32), 32'h0);
    @(negedge clock) reset_n = 1'b1;
    #1 chk_quiet("rm_after");
    @(negedge clock);
    bus.w_addr_0 = 32'h80020010; bus.w_write_0 = 1'b0; bus.w_byte_0 = 1'b0; bus.w_req_0 = 1'b1;
    bus.w_addr_1 = 32'h80020011; bus.w_write_1 = 1'b0; bus.w_byte_1 = 1'b1; bus.w_req_1 = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(posedge clock); #1;
      chk($sformatf("rr%0d", n + 1), 32'({bus.w_gnt_0, bus.w_gnt_1, bus.w_done_0, bus.w_done_1}), 32'(rr_exp[n]));
      if (rr_exp[n] == 4'b0010) chk($sformatf("rr%0d/rdata0", n + 1), bus.w_rdata, 32'hDE5ABEEF);
      if (rr_exp[n] == 4'b0001) chk($sformatf("rr%0d/rdata1", n + 1), bus.w_rdata, 32'h0000005A);
    end
    bus.w_req_0 = 1'b0;
    bus.w_req_1 = 1'b0;
    @(posedge clock);
    @(negedge clock) force dut.err_cnt = 16'hFFFE;
    @(negedge clock) release dut.err_cnt;
    #1 chk("sat/preset", 32'(bus.w_err_count), 32'h0000FFFE);
    op("sat1", 1'b0, 32'h80020001, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("sat/after1", 32'(bus.w_err_count), 32'h0000FFFF);
    op("sat2", 1'b1, 32'h00000000, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1);
    op("sat3", 1'b0, 32'hFFFFFFFC, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("sat/after3", 32'(bus.w_err_count), 32'h0000FFFF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
